// File: rtl/core_bus_bridge.sv
// Single-beat uncached bridge: arbitrates ibus/dbus requests onto one cbus port.
// Types shared with the fetch/memory stages and the AXI adapter live in core_bus_bridge_pkg.
package core_bus_bridge_pkg;
   typedef logic [2:0] msize_t;
   typedef logic [3:0] mlen_t;
   typedef logic [1:0] axi_burst_t;

   localparam msize_t     MSIZE1         = 3'd0;
   localparam msize_t     MSIZE2         = 3'd1;
   localparam msize_t     MSIZE4         = 3'd2;
   localparam msize_t     MSIZE8         = 3'd3;
   localparam mlen_t      MLEN1          = 4'd0;
   localparam axi_burst_t AXI_BURST_INCR = 2'b01;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      msize_t      size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      mlen_t       len;
      axi_burst_t  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module core_bus_bridge
   import core_bus_bridge_pkg::*;
#(
   parameter int unsigned DFIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  ibus_req_t  ireq,
   output ibus_resp_t iresp,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output cbus_req_t  creq,
   input  cbus_resp_t cresp
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   logic [1:0] state_q, state_d;
   logic       last_d_q, last_d_d;   // 1: most recent completed grant was D
   cbus_req_t  lat_q, lat_d;
   logic       grant_i, grant_d, done;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == IDLE) begin
         if (dreq.valid && ireq.valid) begin
            if (DFIXED_PRIO != 0 || !last_d_q) grant_d = 1'b1;
            else                               grant_i = 1'b1;
         end else if (dreq.valid) begin
            grant_d = 1'b1;
         end else if (ireq.valid) begin
            grant_i = 1'b1;
         end
      end
      done = (state_q != IDLE) && cresp.ready && cresp.last;
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      lat_d    = lat_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d        = BUSY_D;
               lat_d          = '0;
               lat_d.valid    = 1'b1;
               lat_d.is_write = |dreq.strobe;
               lat_d.size     = dreq.size;
               lat_d.addr     = dreq.addr;
               lat_d.strobe   = dreq.strobe;
               lat_d.data     = dreq.data;
               lat_d.len      = MLEN1;
               lat_d.burst    = AXI_BURST_INCR;
            end else if (grant_i) begin
               state_d        = BUSY_I;
               lat_d          = '0;
               lat_d.valid    = 1'b1;
               lat_d.size     = MSIZE4;
               lat_d.addr     = ireq.addr;
               lat_d.len      = MLEN1;
               lat_d.burst    = AXI_BURST_INCR;
            end
         end
         BUSY_I: begin
            if (done) begin
               state_d  = IDLE;
               last_d_d = 1'b0;
            end
         end
         BUSY_D: begin
            if (done) begin
               state_d  = IDLE;
               last_d_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Responses are combinational so data_ok lines up with the completing cbus beat.
   always_comb begin
      iresp         = '0;
      dresp         = '0;
      creq          = (state_q != IDLE) ? lat_q : '0;
      iresp.addr_ok = grant_i;
      dresp.addr_ok = grant_d;
      if (state_q == BUSY_I && done) begin
         iresp.data_ok = 1'b1;
         iresp.data    = lat_q.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
      end
      if (state_q == BUSY_D && done) begin
         dresp.data_ok = 1'b1;
         dresp.data    = cresp.data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         lat_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         lat_q    <= lat_d;
      end
   end

endmodule

// File: tb/tb_core_bus_bridge.sv
// Directed bench for core_bus_bridge: one instance per priority mode, shared stimulus.
module tb_core_bus_bridge;
  import core_bus_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  dbus_req_t  dreq;
  cbus_resp_t cresp;
  ibus_resp_t iresp0, iresp1;
  dbus_resp_t dresp0, dresp1;
  cbus_req_t  creq0, creq1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  core_bus_bridge #(.DFIXED_PRIO(0)) dut0 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp0),
    .dreq(dreq), .dresp(dresp0), .creq(creq0), .cresp(cresp)
  );

  core_bus_bridge #(.DFIXED_PRIO(1)) dut1 (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp1),
    .dreq(dreq), .dresp(dresp1), .creq(creq1), .cresp(cresp)
  );

  task automatic expect_ok(input logic ok, input string tag);
    tests++;
    if (ok !== 1'b1) begin
      failed++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    tick;
    tick;
    expect_ok(creq0 === '0, "reset_creq0");
    expect_ok(iresp0 === '0, "reset_iresp0");
    expect_ok(dresp0 === '0, "reset_dresp0");
    expect_ok(creq1 === '0, "reset_creq1");
    reset = 1'b0;

    // D read, zero wait
    tick;
    dreq = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    #1;
    expect_ok(dresp0.addr_ok === 1'b1, "drd_c0_addr_ok");
    expect_ok(iresp0.addr_ok === 1'b0, "drd_c0_iaddr_ok");
    expect_ok(creq0.valid === 1'b0, "drd_c0_creq_valid");
    tick;
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'h1122_3344_5566_7788};
    #1;
    expect_ok(creq0.valid === 1'b1, "drd_c1_creq_valid");
    expect_ok(creq0.is_write === 1'b0, "drd_c1_is_write");
    expect_ok(creq0.len === MLEN1, "drd_c1_len");
    expect_ok(creq0.addr === 32'h8000_0010, "drd_c1_addr");
    expect_ok(creq0.size === MSIZE8, "drd_c1_size");
    expect_ok(creq0.burst === AXI_BURST_INCR, "drd_c1_burst");
    expect_ok(dresp0.addr_ok === 1'b0, "drd_c1_addr_ok");
    expect_ok(dresp0.data_ok === 1'b1, "drd_c1_data_ok");
    expect_ok(dresp0.data === 64'h1122_3344_5566_7788, "drd_c1_data");
    tick;
    dreq  = '0;
    cresp = '0;
    #1;
    expect_ok(creq0.valid === 1'b0, "drd_c2_creq_valid");
    expect_ok(dresp0.data_ok === 1'b0, "drd_c2_data_ok");

    // I fetch, upper word, 3 wait cycles
    ireq = '{valid: 1'b1, addr: 32'h8000_0004};
    #1;
    expect_ok(iresp0.addr_ok === 1'b1, "ifet_c0_addr_ok");
    expect_ok(creq0.valid === 1'b0, "ifet_c0_creq_valid");
    for (int c = 1; c <= 3; c++) begin
      tick;
      expect_ok(iresp0.data_ok === 1'b0, "ifet_wait_data_ok");
      expect_ok(creq0.valid === 1'b1, "ifet_wait_creq_valid");
    end
    expect_ok(creq0.size === MSIZE4, "ifet_size");
    expect_ok(creq0.is_write === 1'b0, "ifet_is_write");
    expect_ok(creq0.strobe === 8'h00, "ifet_strobe");
    expect_ok(creq0.addr === 32'h8000_0004, "ifet_addr");
    tick;
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD_BEEF_0000_0013};
    #1;
    expect_ok(iresp0.data_ok === 1'b1, "ifet_c4_data_ok");
    expect_ok(iresp0.data === 32'hDEAD_BEEF, "ifet_c4_data");
    expect_ok(dresp0 === '0, "ifet_c4_dresp");
    tick;
    ireq  = '0;
    cresp = '0;
    #1;
    expect_ok(creq0.valid === 1'b0, "ifet_c5_creq_valid");

    // Tie arbitration with both buses held and zero-wait memory
    ireq  = '{valid: 1'b1, addr: 32'h8000_0000};
    dreq  = '{valid: 1'b1, addr: 32'h8000_0040, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'h0123_4567_89AB_CDEF};
    #1;
    for (int k = 0; k < 4; k++) begin
      expect_ok(dresp0.addr_ok === ((k % 2) == 0), "tie_p0_d_grant");
      expect_ok(iresp0.addr_ok === ((k % 2) == 1), "tie_p0_i_grant");
      expect_ok(dresp1.addr_ok === 1'b1, "tie_p1_d_grant");
      expect_ok(iresp1.addr_ok === 1'b0, "tie_p1_i_grant");
      tick;
      if ((k % 2) == 1) begin
        expect_ok(iresp0.data_ok === 1'b1, "tie_i_data_ok");
        expect_ok(iresp0.data === 32'h89AB_CDEF, "tie_i_data");
      end else begin
        expect_ok(dresp0.data_ok === 1'b1, "tie_d_data_ok");
        expect_ok(dresp0.data === 64'h0123_4567_89AB_CDEF, "tie_d_data");
      end
      expect_ok(dresp1.data_ok === 1'b1, "tie_p1_d_data_ok");
      tick;
    end
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    #1;
    expect_ok(creq0.valid === 1'b0, "tie_end_creq_valid");

    // D write
    dreq = '{valid: 1'b1, addr: 32'h8000_0100, size: MSIZE4, strobe: 8'h0F, data: 64'hAABB_CCDD};
    #1;
    expect_ok(dresp0.addr_ok === 1'b1, "dwr_c0_addr_ok");
    tick;
    expect_ok(creq0.is_write === 1'b1, "dwr_c1_is_write");
    expect_ok(creq0.strobe === 8'h0F, "dwr_c1_strobe");
    expect_ok(creq0.data === 64'hAABB_CCDD, "dwr_c1_data");
    expect_ok(creq0.size === MSIZE4, "dwr_c1_size");
    expect_ok(dresp0.data_ok === 1'b0, "dwr_c1_data_ok");
    tick;
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    #1;
    expect_ok(dresp0.data_ok === 1'b1, "dwr_c2_data_ok");
    expect_ok(creq0.valid === 1'b1, "dwr_c2_creq_valid");
    tick;
    dreq  = '0;
    cresp = '0;
    #1;

    // Stray beat: ready without last must be ignored
    dreq = '{valid: 1'b1, addr: 32'h8000_0020, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    #1;
    expect_ok(dresp0.addr_ok === 1'b1, "stray_c0_addr_ok");
    tick;
    cresp = '{ready: 1'b1, last: 1'b0, data: 64'hFFFF_FFFF_FFFF_FFFF};
    #1;
    expect_ok(dresp0.data_ok === 1'b0, "stray_c1_data_ok");
    expect_ok(dresp0.data === 64'h0, "stray_c1_data");
    tick;
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'h5555_AAAA_1234_5678};
    #1;
    expect_ok(creq0.valid === 1'b1, "stray_c2_creq_valid");
    expect_ok(dresp0.data_ok === 1'b1, "stray_c2_data_ok");
    expect_ok(dresp0.data === 64'h5555_AAAA_1234_5678, "stray_c2_data");
    tick;
    dreq  = '0;
    cresp = '0;
    #1;
    expect_ok(dresp0.data_ok === 1'b0, "stray_c3_data_ok");
    expect_ok(creq0.valid === 1'b0, "stray_c3_creq_valid");

    // Reset mid-transaction; last grant was D, so only a reset makes D win the next tie
    dreq = '{valid: 1'b1, addr: 32'h8000_0080, size: MSIZE8, strobe: 8'h00, data: 64'h0};
    #1;
    expect_ok(dresp0.addr_ok === 1'b1, "rst_c0_addr_ok");
    tick;
    expect_ok(creq0.valid === 1'b1, "rst_c1_creq_valid");
    reset = 1'b1;
    tick;
    reset = 1'b0;
    ireq  = '{valid: 1'b1, addr: 32'h8000_0008};
    #1;
    expect_ok(creq0 === '0, "rst_c2_creq");
    expect_ok(dresp0.data_ok === 1'b0, "rst_c2_data_ok");
    expect_ok(iresp0.data_ok === 1'b0, "rst_c2_idata_ok");
    expect_ok(dresp0.addr_ok === 1'b1, "rst_tie_d_grant");
    expect_ok(iresp0.addr_ok === 1'b0, "rst_tie_i_grant");
    tick;
    cresp = '{ready: 1'b1, last: 1'b1, data: 64'h0};
    #1;
    expect_ok(dresp0.data_ok === 1'b1, "rst_c3_data_ok");
    tick;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
